if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the 16-bit pipelined RISC core. Owns the program counter, the instruction-memory address, and the IF/ID pipeline register. Consumes the branch/jump redirect (`ex_redirect`, `ex_sel`) resolved in EX and the load-use stall from the decode hazard logic. Squashes younger in-flight instructions on a taken BEQ/JLR and keeps saturating redirect and stall counters for debug.

## Interface
- `PC_WIDTH`, 16, PC and address width.
- `INSTR_WIDTH`, 16, instruction word width.
- `RESET_PC`, 16'h0000, first fetch address after reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  load-use stall: hold PC and IF/ID.
- `ex_redirect`  in  1  taken BEQ/JLR in EX, already gated by EX validity.
- `ex_sel`  in  2  01 = JLR target, 10 = BEQ target, 00/11 = no redirect.
- `ex_jlr_target`  in  PC_WIDTH  register value for JLR.
- `ex_beq_target`  in  PC_WIDTH  PC+imm computed in EX.
- `imem_addr`  out  PC_WIDTH  combinational read address; equals PC.
- `imem_data`  in  INSTR_WIDTH  instruction returned in the same cycle.
- `if_id_instr`  out  INSTR_WIDTH  registered instruction.
- `if_id_pc`  out  PC_WIDTH  PC of `if_id_instr`.
- `if_id_pc_inc`  out  PC_WIDTH  `if_id_pc`+1, for the JAL/JLR link.
- `if_id_invalid`  out  1  1 = bubble; downstream stages treat the slot as NOP.
- `kill_id`, `kill_rr`  out  1 each  squash ID and RR contents; combinational, equal to the effective redirect.
- `redirect_count`, `stall_count`  out  16 each  saturating event counters.

## Operation
- Effective redirect: `redir = ex_redirect & (ex_sel==01 | ex_sel==10)`. When `ex_sel` is 00 or 11 with `ex_redirect`=1, the redirect is ignored and `redirect_count` is not incremented.
- Next PC priority, highest first:
  - reset → `RESET_PC`;
  - redir → `ex_jlr_target` (sel 01) or `ex_beq_target` (sel 10);
  - stall → hold;
  - otherwise PC+1, wrapping modulo 2^PC_WIDTH (FFFF → 0000).
- IF/ID update priority:
  - reset → `if_id_invalid`=1, instr=0, pc=0, pc_inc=0;
  - redir → `if_id_invalid`=1, other fields don't-care, held at old values;
  - stall → hold all fields;
  - state BOOT → `if_id_invalid`=1;
  - else load {`imem_data`, PC, PC+1} with `if_id_invalid`=0.
- Redirect wins over stall in the same cycle. The stalled instruction is younger than the branch and is killed.
- State machine, 2 states:
  - BOOT is entered on reset. It lasts exactly one cycle, during which `imem_addr`=`RESET_PC` and no valid instruction is captured. Then BOOT → RUN unconditionally.
  - RUN is left only by reset.
  - A stall or redir during BOOT is ignored.
- Counters:
  - `redirect_count` +1 per cycle with redir.
  - `stall_count` +1 per cycle with stall and no redir.
  - Both saturate at FFFF and clear on reset.

## Timing
- Reset values: PC=`RESET_PC`, state=BOOT, `if_id_invalid`=1, instr/pc/pc_inc=0, counters=0. `kill_id`/`kill_rr` follow the inputs, are 0 when inputs are idle, and are forced 0 while `reset`=1.
- Fetch latency: the instruction at PC in cycle t appears on `if_id_*` in cycle t+1.
- Redirect asserted in cycle t:
  - `kill_*`=1 in cycle t;
  - PC=target and `if_id_invalid`=1 in t+1;
  - target instruction valid on IF/ID in t+2.
- Back-to-back redirects in t and t+1: the second one (from the older EX instruction's successor) wins. PC=second target at t+2.
- Reset asserted mid-stall or mid-redirect overrides everything at the next edge.
- First valid IF/ID after reset release: `RESET_PC` instruction, 2 cycles after the first non-reset edge.

## Structure
- Shared package `risc_pkg`: `PC_WIDTH`, `INSTR_WIDTH`, sel encodings `SEL_SEQ`=00, `SEL_JLR`=01, `SEL_BEQ`=10, opcode constants BEQ=4'b1100 and JLR=4'b1001, and the fetch-state enum.
- One sub-module: `sat_counter16`, with enable and synchronous clear, instantiated twice.
- PC mux, IF/ID register, and FSM stay inline.

## Test plan
- Reset released, `imem` returns addr+16'hA000, no stall: BOOT for 1 cycle; IF/ID shows (A000, pc 0, inc 1), then (A001, 1, 2), and so on.
- Stall held cycles 5–7: PC and IF/ID frozen; `stall_count`=3; fetch resumes at the same PC.
- `ex_redirect`=1, sel=10, `beq_target`=0x0040 in cycle t, with stall=1 in t: `kill_*`=1 in t; `if_id_invalid`=1 in t+1; IF/ID pc=0x0040 in t+2; `redirect_count`=1; `stall_count` unchanged.
- sel=01, `jlr_target`=0x1234, then sel=10 to 0x0010 the next cycle: final PC path is 0x0010; `redirect_count`=2.
- `ex_redirect`=1 with sel=11: no redirect, `kill_*`=0, sequential fetch continues.
- PC preloaded via redirect to 0xFFFF: next fetch address is 0x0000. Also, 70000 stall cycles → `stall_count`=FFFF (saturated); reset mid-stall → all reset values next cycle.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared constants and types for the 16-bit pipelined RISC core.
//   PC_WIDTH / INSTR_WIDTH  default datapath widths
//   SEL_*                   EX redirect-source encodings on ex_sel
//   OP_BEQ / OP_JLR         opcodes of the two redirecting instructions
//   fetch_state_e           fetch-stage FSM states
package risc_pkg;

  localparam int PC_WIDTH    = 16;
  localparam int INSTR_WIDTH = 16;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_JLR = 2'b01;
  localparam logic [1:0] SEL_BEQ = 2'b10;

  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_JLR = 4'b1001;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at FFFF.
//   clk      clock
//   clr_i    synchronous clear, wins over enable
//   en_i     count one event this cycle
//   count_o  current count
module sat_counter16 (
  input  logic        clk,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (clr_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch for the 16-bit RISC pipeline.
//   clk, reset                 clock, synchronous active-high reset
//   stall                      load-use stall, holds PC and IF/ID
//   ex_redirect, ex_sel        taken BEQ/JLR from EX and its target source
//   ex_jlr_target, ex_beq_target  candidate redirect targets
//   imem_addr / imem_data      combinational instruction-memory port
//   if_id_*                    IF/ID pipeline register (instr, pc, pc+1, bubble)
//   kill_id, kill_rr           squash younger ID/RR contents on redirect
//   redirect_count, stall_count  saturating debug counters
module if_fetch_stage #(
  parameter int                    PC_WIDTH    = risc_pkg::PC_WIDTH,
  parameter int                    INSTR_WIDTH = risc_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   ex_redirect,
  input  logic [1:0]             ex_sel,
  input  logic [PC_WIDTH-1:0]    ex_jlr_target,
  input  logic [PC_WIDTH-1:0]    ex_beq_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc,
  output logic [PC_WIDTH-1:0]    if_id_pc_inc,
  output logic                   if_id_invalid,
  output logic                   kill_id,
  output logic                   kill_rr,
  output logic [15:0]            redirect_count,
  output logic [15:0]            stall_count
);
  import risc_pkg::*;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  fetch_state_e            state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d, pc_plus1;
  logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
  logic [PC_WIDTH-1:0]     id_pc_q, id_pc_d, id_inc_q, id_inc_d;
  logic                    inv_q, inv_d;
  logic                    run, redir, stall_eff;

  // Redirects and stalls only act once the stage is running and out of reset;
  // sel 00/11 is a malformed redirect and is dropped entirely.
  assign run       = (state_q == ST_RUN) && !reset;
  assign redir     = run && ex_redirect && ((ex_sel == SEL_JLR) || (ex_sel == SEL_BEQ));
  assign stall_eff = run && stall;
  assign pc_plus1  = pc_q + PC_ONE;

  // FSM next state: BOOT lasts one cycle, RUN is left only through reset.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_BOOT) state_d = ST_RUN;
  end

  // PC and IF/ID next state; redirect outranks stall.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    id_pc_d  = id_pc_q;
    id_inc_d = id_inc_q;
    inv_d    = inv_q;
    if (redir) begin
      pc_d  = (ex_sel == SEL_JLR) ? ex_jlr_target : ex_beq_target;
      inv_d = 1'b1;
    end else if (stall_eff) begin
      // hold everything
    end else if (state_q == ST_BOOT) begin
      // PC stays at RESET_PC so its instruction is captured on the first RUN cycle
      inv_d = 1'b1;
    end else begin
      pc_d     = pc_plus1;
      instr_d  = imem_data;
      id_pc_d  = pc_q;
      id_inc_d = pc_plus1;
      inv_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      id_pc_q  <= '0;
      id_inc_q <= '0;
      inv_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      id_pc_q  <= id_pc_d;
      id_inc_q <= id_inc_d;
      inv_q    <= inv_d;
    end
  end

  sat_counter16 u_redir_cnt (
    .clk     (clk),
    .clr_i   (reset),
    .en_i    (redir),
    .count_o (redirect_count)
  );

  sat_counter16 u_stall_cnt (
    .clk     (clk),
    .clr_i   (reset),
    .en_i    (stall_eff && !redir),
    .count_o (stall_count)
  );

  assign imem_addr     = pc_q;
  assign if_id_instr   = instr_q;
  assign if_id_pc      = id_pc_q;
  assign if_id_pc_inc  = id_inc_q;
  assign if_id_invalid = inv_q;
  assign kill_id       = redir;
  assign kill_rr       = redir;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, ex_redirect;
  logic [1:0]  ex_sel;
  logic [15:0] ex_jlr_target, ex_beq_target;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] if_id_instr, if_id_pc, if_id_pc_inc;
  logic        if_id_invalid, kill_id, kill_rr;
  logic [15:0] redirect_count, stall_count;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word at address a is a + A000.
  assign imem_data = imem_addr + 16'hA000;

  if_fetch_stage #(.PC_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .ex_redirect    (ex_redirect),
    .ex_sel         (ex_sel),
    .ex_jlr_target  (ex_jlr_target),
    .ex_beq_target  (ex_beq_target),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_inc   (if_id_pc_inc),
    .if_id_invalid  (if_id_invalid),
    .kill_id        (kill_id),
    .kill_rr        (kill_rr),
    .redirect_count (redirect_count),
    .stall_count    (stall_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    stall = 0; ex_redirect = 0; ex_sel = 2'b00;
    ex_jlr_target = 16'h0000; ex_beq_target = 16'h0000;
  endtask

  task automatic chk_ifid(input string tag, input logic [15:0] instr, input logic [15:0] pc,
                          input logic [15:0] inc, input logic inv);
    chk({tag, ".instr"}, if_id_instr, instr);
    chk({tag, ".pc"}, if_id_pc, pc);
    chk({tag, ".inc"}, if_id_pc_inc, inc);
    chk({tag, ".inv"}, {15'd0, if_id_invalid}, {15'd0, inv});
  endtask

  initial begin
    idle();
    reset = 1;
    cyc(); cyc();
    // reset state
    chk("rst.addr", imem_addr, 16'h0000);
    chk_ifid("rst", 16'h0000, 16'h0000, 16'h0000, 1'b1);
    chk("rst.rcnt", redirect_count, 16'h0000);
    chk("rst.scnt", stall_count, 16'h0000);
    ex_redirect = 1; ex_sel = 2'b10; ex_beq_target = 16'h0040; #1;
    chk("rst.kill_id", {15'd0, kill_id}, 16'h0000);
    idle();

    // BOOT cycle: redirect/stall ignored
    reset = 0;
    stall = 1; ex_redirect = 1; ex_sel = 2'b10; ex_beq_target = 16'h0040; #1;
    chk("boot.addr", imem_addr, 16'h0000);
    chk("boot.kill_rr", {15'd0, kill_rr}, 16'h0000);
    cyc(); idle();
    chk("run0.addr", imem_addr, 16'h0000);
    chk("run0.inv", {15'd0, if_id_invalid}, 16'h0001);
    chk("run0.rcnt", redirect_count, 16'h0000);
    chk("run0.scnt", stall_count, 16'h0000);
    cyc();
    chk_ifid("f0", 16'hA000, 16'h0000, 16'h0001, 1'b0);
    chk("f0.addr", imem_addr, 16'h0001);
    cyc();
    chk_ifid("f1", 16'hA001, 16'h0001, 16'h0002, 1'b0);
    cyc();
    chk_ifid("f2", 16'hA002, 16'h0002, 16'h0003, 1'b0);
    chk("f2.addr", imem_addr, 16'h0003);

    // three stall cycles
    stall = 1;
    cyc();
    chk_ifid("st1", 16'hA002, 16'h0002, 16'h0003, 1'b0);
    chk("st1.addr", imem_addr, 16'h0003);
    cyc();
    chk("st2.addr", imem_addr, 16'h0003);
    cyc();
    chk_ifid("st3", 16'hA002, 16'h0002, 16'h0003, 1'b0);
    chk("st3.scnt", stall_count, 16'h0003);
    stall = 0;
    cyc();
    chk_ifid("resume", 16'hA003, 16'h0003, 16'h0004, 1'b0);
    chk("resume.addr", imem_addr, 16'h0004);

    // BEQ redirect with simultaneous stall
    stall = 1; ex_redirect = 1; ex_sel = 2'b10; ex_beq_target = 16'h0040; #1;
    chk("beq.kill_id", {15'd0, kill_id}, 16'h0001);
    chk("beq.kill_rr", {15'd0, kill_rr}, 16'h0001);
    cyc(); idle();
    chk("beq1.addr", imem_addr, 16'h0040);
    chk("beq1.inv", {15'd0, if_id_invalid}, 16'h0001);
    chk("beq1.rcnt", redirect_count, 16'h0001);
    chk("beq1.scnt", stall_count, 16'h0003);
    cyc();
    chk_ifid("beq2", 16'hA040, 16'h0040, 16'h0041, 1'b0);

    // back-to-back JLR then BEQ
    ex_redirect = 1; ex_sel = 2'b01; ex_jlr_target = 16'h1234; ex_beq_target = 16'h5555; #1;
    chk("jlr.kill_id", {15'd0, kill_id}, 16'h0001);
    cyc();
    chk("jlr.addr", imem_addr, 16'h1234);
    ex_redirect = 1; ex_sel = 2'b10; ex_beq_target = 16'h0010; ex_jlr_target = 16'h7777;
    cyc(); idle();
    chk("b2b.addr", imem_addr, 16'h0010);
    chk("b2b.inv", {15'd0, if_id_invalid}, 16'h0001);
    chk("b2b.rcnt", redirect_count, 16'h0003);
    cyc();
    chk_ifid("b2b2", 16'hA010, 16'h0010, 16'h0011, 1'b0);

    // sel=11 is not a redirect
    ex_redirect = 1; ex_sel = 2'b11; ex_jlr_target = 16'h0100; ex_beq_target = 16'h0200; #1;
    chk("sel11.kill_id", {15'd0, kill_id}, 16'h0000);
    cyc(); idle();
    chk("sel11.addr", imem_addr, 16'h0012);
    chk_ifid("sel11", 16'hA011, 16'h0011, 16'h0012, 1'b0);
    chk("sel11.rcnt", redirect_count, 16'h0003);

    // PC wrap at FFFF
    ex_redirect = 1; ex_sel = 2'b01; ex_jlr_target = 16'hFFFF;
    cyc(); idle();
    chk("wrap0.addr", imem_addr, 16'hFFFF);
    cyc();
    chk_ifid("wrap1", 16'h9FFF, 16'hFFFF, 16'h0000, 1'b0);
    chk("wrap1.addr", imem_addr, 16'h0000);
    chk("wrap1.rcnt", redirect_count, 16'h0004);

    // stall counter saturation
    stall = 1;
    repeat (70000) @(posedge clk);
    #2;
    chk("sat.scnt", stall_count, 16'hFFFF);
    chk("sat.addr", imem_addr, 16'h0000);
    chk("sat.pc", if_id_pc, 16'hFFFF);

    // reset mid-stall with a redirect pending
    reset = 1; ex_redirect = 1; ex_sel = 2'b10; ex_beq_target = 16'h0040; #1;
    chk("rst2.kill_id", {15'd0, kill_id}, 16'h0000);
    cyc();
    chk("rst2.addr", imem_addr, 16'h0000);
    chk_ifid("rst2", 16'h0000, 16'h0000, 16'h0000, 1'b1);
    chk("rst2.rcnt", redirect_count, 16'h0000);
    chk("rst2.scnt", stall_count, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
